wb_scheduler: RTL and testbench

Writeback scheduler for the pipelined CPU's dual-write-port register file. Three writeback sources (main pipeline, multiply/divide unit, load unit) compete for the two register-file write ports (X and Y). Each cycle it grants up to two requests, never grants two writes to the same register in one cycle, and bounds the wait of the secondary sources. It registers the winning writes onto the register file's X/Y write ports one cycle after acceptance.

---
 rtl/wb_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_wb_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_scheduler.sv
// Writeback scheduler: arbitrates three writeback sources onto the two register-file
// write ports, never granting two writes to one register in a cycle, with bounded wait.
module wb_scheduler #(
    parameter int MAXWAIT = 4
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        r0_valid,
    input  logic [4:0]  r0_rd,
    input  logic [31:0] r0_data,
    output logic        r0_ready,
    input  logic        r1_valid,
    input  logic [4:0]  r1_rd,
    input  logic [31:0] r1_data,
    output logic        r1_ready,
    input  logic        r2_valid,
    input  logic [4:0]  r2_rd,
    input  logic [31:0] r2_data,
    output logic        r2_ready,
    output logic        wex,
    output logic [4:0]  wnx,
    output logic [31:0] dx,
    output logic        wey,
    output logic [4:0]  wny,
    output logic [31:0] dy
);

    localparam logic [3:0] WAIT_MAX = 4'(MAXWAIT);
    localparam logic [1:0] SRC_R0   = 2'd0;
    localparam logic [1:0] SRC_R1   = 2'd1;
    localparam logic [1:0] SRC_R2   = 2'd2;

    logic [2:0]  vld;
    logic [2:0]  cand;
    logic [2:0]  gnt;
    logic [2:0]  rdy;
    logic [4:0]  rd_a   [3];
    logic [31:0] data_a [3];
    logic [1:0]  urg;

    logic        rr_reg;
    logic        rr_next;

    logic [1:0]  ord [3];
    logic [1:0]  sec_a;
    logic [1:0]  sec_b;
    logic        urg_a;
    logic        urg_b;

    logic        x_gnt;
    logic        y_gnt;
    logic [1:0]  x_sel;
    logic [1:0]  y_sel;

    logic        wex_reg;
    logic        wey_reg;
    logic [4:0]  wnx_reg;
    logic [4:0]  wny_reg;
    logic [31:0] dx_reg;
    logic [31:0] dy_reg;

    assign vld       = {r2_valid, r1_valid, r0_valid};
    assign rd_a[0]   = r0_rd;
    assign rd_a[1]   = r1_rd;
    assign rd_a[2]   = r2_rd;
    assign data_a[0] = r0_data;
    assign data_a[1] = r1_data;
    assign data_a[2] = r2_data;

    // rd == 0 needs no port, so it is accepted as soon as it is valid.
    // Ready is held low while clrn is high so nothing is accepted and then dropped.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_src
            assign cand[gi] = vld[gi] && (rd_a[gi] != 5'd0);
            assign rdy[gi]  = !clrn && vld[gi] && ((rd_a[gi] == 5'd0) || gnt[gi]);
        end
    endgenerate

    assign r0_ready = rdy[0];
    assign r1_ready = rdy[1];
    assign r2_ready = rdy[2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_wait
            logic [3:0] cnt_reg;
            logic [3:0] cnt_next;

            always_comb begin
                cnt_next = cnt_reg;
                if (!vld[gi+1] || rdy[gi+1]) begin
                    cnt_next = 4'd0;
                end else if (cand[gi+1] && !gnt[gi+1] && (cnt_reg < WAIT_MAX)) begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end

            always_ff @(posedge clk or posedge clrn) begin
                if (clrn) begin
                    cnt_reg <= 4'd0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            assign urg[gi] = (cnt_reg == WAIT_MAX);
        end
    endgenerate

    // sec_a is the secondary currently favoured by the round-robin pointer.
    assign sec_a = rr_reg ? SRC_R2 : SRC_R1;
    assign sec_b = rr_reg ? SRC_R1 : SRC_R2;
    assign urg_a = rr_reg ? urg[1] : urg[0];
    assign urg_b = rr_reg ? urg[0] : urg[1];

    always_comb begin
        ord[0] = SRC_R0;
        ord[1] = sec_a;
        ord[2] = sec_b;
        case ({urg_a, urg_b})
            2'b10: begin
                ord[0] = sec_a;
                ord[1] = SRC_R0;
                ord[2] = sec_b;
            end
            2'b01: begin
                ord[0] = sec_b;
                ord[1] = SRC_R0;
                ord[2] = sec_a;
            end
            2'b11: begin
                ord[0] = sec_a;
                ord[1] = sec_b;
                ord[2] = SRC_R0;
            end
            default: begin
                ord[0] = SRC_R0;
                ord[1] = sec_a;
                ord[2] = sec_b;
            end
        endcase
    end

    // Only the X grant can collide with a later candidate, since Y is the last slot.
    always_comb begin
        gnt   = 3'b000;
        x_gnt = 1'b0;
        y_gnt = 1'b0;
        x_sel = SRC_R0;
        y_sel = SRC_R0;
        for (int k = 0; k < 3; k++) begin
            if (cand[ord[k]]) begin
                if (!x_gnt) begin
                    x_gnt        = 1'b1;
                    x_sel        = ord[k];
                    gnt[ord[k]]  = 1'b1;
                end else if (!y_gnt && (rd_a[ord[k]] != rd_a[x_sel])) begin
                    y_gnt        = 1'b1;
                    y_sel        = ord[k];
                    gnt[ord[k]]  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rr_next = rr_reg;
        if (gnt[1] ^ gnt[2]) begin
            rr_next = gnt[1];
        end
    end

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            rr_reg <= 1'b0;
        end else begin
            rr_reg <= rr_next;
        end
    end

    // Address/data hold stale values while the matching enable is low.
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            wex_reg <= 1'b0;
            wey_reg <= 1'b0;
            wnx_reg <= 5'd0;
            wny_reg <= 5'd0;
            dx_reg  <= 32'd0;
            dy_reg  <= 32'd0;
        end else begin
            wex_reg <= x_gnt;
            wey_reg <= y_gnt;
            if (x_gnt) begin
                wnx_reg <= rd_a[x_sel];
                dx_reg  <= data_a[x_sel];
            end
            if (y_gnt) begin
                wny_reg <= rd_a[y_sel];
                dy_reg  <= data_a[y_sel];
            end
        end
    end

    assign wex = wex_reg;
    assign wey = wey_reg;
    assign wnx = wnx_reg;
    assign wny = wny_reg;
    assign dx  = dx_reg;
    assign dy  = dy_reg;

endmodule

// File: tb/tb_wb_scheduler.sv
// Directed and randomized bench for wb_scheduler against a priority-list reference model.
module tb_wb_scheduler;

    localparam int MAXWAIT = 4;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        r0_valid = 1'b0, r1_valid = 1'b0, r2_valid = 1'b0;
    logic [4:0]  r0_rd = '0, r1_rd = '0, r2_rd = '0;
    logic [31:0] r0_data = '0, r1_data = '0, r2_data = '0;
    logic        r0_ready, r1_ready, r2_ready;
    logic        wex, wey;
    logic [4:0]  wnx, wny;
    logic [31:0] dx, dy;

    always #5 clk = ~clk;

    wb_scheduler #(.MAXWAIT(MAXWAIT)) dut (
        .clk(clk), .clrn(clrn),
        .r0_valid(r0_valid), .r0_rd(r0_rd), .r0_data(r0_data), .r0_ready(r0_ready),
        .r1_valid(r1_valid), .r1_rd(r1_rd), .r1_data(r1_data), .r1_ready(r1_ready),
        .r2_valid(r2_valid), .r2_rd(r2_rd), .r2_data(r2_data), .r2_ready(r2_ready),
        .wex(wex), .wnx(wnx), .dx(dx),
        .wey(wey), .wny(wny), .dy(dy)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          m_rr;
    int          m_w [3];
    bit          m_gnt [3];
    bit          m_rdy [3];
    int          xs, ys;
    logic        e_wex, e_wey;
    logic [4:0]  e_wnx, e_wny;
    logic [31:0] e_dx, e_dy;
    logic        o_rdy [3];

    function automatic logic get_v(int i);
        case (i)
            0: return r0_valid;
            1: return r1_valid;
            default: return r2_valid;
        endcase
    endfunction

    function automatic int get_rd(int i);
        case (i)
            0: return int'(r0_rd);
            1: return int'(r1_rd);
            default: return int'(r2_rd);
        endcase
    endfunction

    function automatic logic [31:0] get_d(int i);
        case (i)
            0: return r0_data;
            1: return r1_data;
            default: return r2_data;
        endcase
    endfunction

    task automatic set_req(int i, logic v, logic [4:0] rd, logic [31:0] d);
        case (i)
            0: begin r0_valid = v; r0_rd = rd; r0_data = d; end
            1: begin r1_valid = v; r1_rd = rd; r1_data = d; end
            default: begin r2_valid = v; r2_rd = rd; r2_data = d; end
        endcase
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Priority list: urgent secondaries (rr order), r0, other secondaries (rr order).
    task automatic model_eval();
        int lst[$];
        int taken[$];
        int first, second;
        bit dup;
        for (int i = 0; i < 3; i++) begin
            m_gnt[i] = 1'b0;
            m_rdy[i] = 1'b0;
        end
        xs = -1;
        ys = -1;
        if (clrn) return;
        first  = (m_rr == 0) ? 1 : 2;
        second = 3 - first;
        if (m_w[first] == MAXWAIT) lst.push_back(first);
        if (m_w[second] == MAXWAIT) lst.push_back(second);
        lst.push_back(0);
        if (m_w[first] != MAXWAIT) lst.push_back(first);
        if (m_w[second] != MAXWAIT) lst.push_back(second);
        foreach (lst[k]) begin
            int s = lst[k];
            if (get_v(s) && get_rd(s) != 0 && taken.size() < 2) begin
                dup = 1'b0;
                foreach (taken[j]) if (taken[j] == get_rd(s)) dup = 1'b1;
                if (!dup) begin
                    m_gnt[s] = 1'b1;
                    taken.push_back(get_rd(s));
                    if (xs < 0) xs = s; else ys = s;
                end
            end
        end
        for (int i = 0; i < 3; i++)
            m_rdy[i] = get_v(i) && (get_rd(i) == 0 || m_gnt[i]);
    endtask

    task automatic model_clear();
        m_rr = 0;
        m_w[0] = 0; m_w[1] = 0; m_w[2] = 0;
        e_wex = 1'b0; e_wey = 1'b0;
        e_wnx = '0; e_wny = '0;
        e_dx = '0; e_dy = '0;
    endtask

    task automatic do_cycle();
        @(negedge clk);
        model_eval();
        o_rdy[0] = r0_ready;
        o_rdy[1] = r1_ready;
        o_rdy[2] = r2_ready;
        chk("r0_ready", 32'(r0_ready), 32'(m_rdy[0]));
        chk("r1_ready", 32'(r1_ready), 32'(m_rdy[1]));
        chk("r2_ready", 32'(r2_ready), 32'(m_rdy[2]));
        @(posedge clk);
        #1;
        if (clrn) begin
            model_clear();
        end else begin
            e_wex = (xs >= 0);
            e_wey = (ys >= 0);
            if (xs >= 0) begin e_wnx = 5'(get_rd(xs)); e_dx = get_d(xs); end
            if (ys >= 0) begin e_wny = 5'(get_rd(ys)); e_dy = get_d(ys); end
            for (int s = 1; s < 3; s++) begin
                if (!get_v(s) || m_rdy[s]) m_w[s] = 0;
                else if (get_rd(s) != 0 && !m_gnt[s] && m_w[s] < MAXWAIT) m_w[s] = m_w[s] + 1;
            end
            if (m_gnt[1] != m_gnt[2]) m_rr = m_gnt[1] ? 1 : 0;
        end
        chk("wex", 32'(wex), 32'(e_wex));
        chk("wey", 32'(wey), 32'(e_wey));
        if (e_wex) begin
            chk("wnx", 32'(wnx), 32'(e_wnx));
            chk("dx", dx, e_dx);
        end
        if (e_wey) begin
            chk("wny", 32'(wny), 32'(e_wny));
            chk("dy", dy, e_dy);
        end
        chk("no_dup_reg", 32'(wex && wey && (wnx == wny)), 32'd0);
    endtask

    task automatic do_reset();
        clrn = 1'b1;
        #1;
        chk("rst_wex", 32'(wex), 32'd0);
        chk("rst_wey", 32'(wey), 32'd0);
        chk("rst_wnx", 32'(wnx), 32'd0);
        chk("rst_wny", 32'(wny), 32'd0);
        chk("rst_dx", dx, 32'd0);
        chk("rst_dy", dy, 32'd0);
        chk("rst_r0_ready", 32'(r0_ready), 32'd0);
        model_clear();
        do_cycle();
        do_cycle();
        clrn = 1'b0;
    endtask

    task automatic idle_all();
        for (int i = 0; i < 3; i++) set_req(i, 1'b0, 5'd0, 32'd0);
    endtask

    logic [31:0] d0, d1, d2;

    initial begin
        // Reset with r0 waiting on rd 3, then first acceptance right after release
        #2;
        d0 = $urandom();
        set_req(0, 1'b1, 5'd3, d0);
        do_reset();
        do_cycle();
        chk("t1_r0_acc", 32'(o_rdy[0]), 32'd1);
        chk("t1_wex", 32'(wex), 32'd1);
        chk("t1_wnx", 32'(wnx), 32'd3);
        chk("t1_wey", 32'(wey), 32'd0);
        idle_all();

        // Three distinct registers
        do_reset();
        d0 = $urandom(); d1 = $urandom(); d2 = $urandom();
        set_req(0, 1'b1, 5'd1, d0);
        set_req(1, 1'b1, 5'd2, d1);
        set_req(2, 1'b1, 5'd3, d2);
        do_cycle();
        chk("t2_rdy2_wait", 32'(o_rdy[2]), 32'd0);
        chk("t2_wnx", 32'(wnx), 32'd1);
        chk("t2_dx", dx, d0);
        chk("t2_wny", 32'(wny), 32'd2);
        chk("t2_dy", dy, d1);
        d0 = $urandom();
        set_req(0, 1'b1, 5'd4, d0);
        set_req(1, 1'b0, 5'd0, 32'd0);
        do_cycle();
        chk("t2_rdy2_acc", 32'(o_rdy[2]), 32'd1);
        chk("t2b_wnx", 32'(wnx), 32'd4);
        chk("t2b_wny", 32'(wny), 32'd3);
        chk("t2b_dy", dy, d2);
        set_req(0, 1'b0, 5'd0, 32'd0);
        set_req(1, 1'b1, 5'd9, $urandom());
        set_req(2, 1'b1, 5'd10, $urandom());
        do_cycle();
        chk("t2_rr_back_x", 32'(wnx), 32'd9);
        chk("t2_rr_back_y", 32'(wny), 32'd10);
        idle_all();

        // Same-register conflict
        do_reset();
        set_req(0, 1'b1, 5'd5, $urandom());
        set_req(1, 1'b1, 5'd5, $urandom());
        set_req(2, 1'b1, 5'd6, $urandom());
        do_cycle();
        chk("t3_rdy1", 32'(o_rdy[1]), 32'd0);
        chk("t3_wnx", 32'(wnx), 32'd5);
        chk("t3_wny", 32'(wny), 32'd6);
        idle_all();

        // Starvation of r2 until it turns urgent
        do_reset();
        d0 = $urandom(); d1 = $urandom(); d2 = $urandom();
        set_req(0, 1'b1, 5'd5, d0);
        set_req(1, 1'b1, 5'd6, d1);
        set_req(2, 1'b1, 5'd5, d2);
        for (int c = 0; c < MAXWAIT; c++) begin
            do_cycle();
            chk("t4_r2_blocked", 32'(o_rdy[2]), 32'd0);
        end
        do_cycle();
        chk("t4_r2_urgent", 32'(o_rdy[2]), 32'd1);
        chk("t4_r0_held", 32'(o_rdy[0]), 32'd0);
        chk("t4_r1_acc", 32'(o_rdy[1]), 32'd1);
        chk("t4_wnx", 32'(wnx), 32'd5);
        chk("t4_dx", dx, d2);
        chk("t4_wny", 32'(wny), 32'd6);
        do_cycle();
        chk("t4_w2_cleared", 32'(o_rdy[2]), 32'd0);
        idle_all();

        // rd == 0 on r0
        do_reset();
        set_req(0, 1'b1, 5'd0, $urandom());
        set_req(1, 1'b1, 5'd7, $urandom());
        set_req(2, 1'b1, 5'd8, $urandom());
        do_cycle();
        chk("t5_rdy0", 32'(o_rdy[0]), 32'd1);
        chk("t5_rdy1", 32'(o_rdy[1]), 32'd1);
        chk("t5_rdy2", 32'(o_rdy[2]), 32'd1);
        chk("t5_wnx", 32'(wnx), 32'd7);
        chk("t5_wny", 32'(wny), 32'd8);
        idle_all();

        // Idle
        for (int c = 0; c < 3; c++) begin
            do_cycle();
            chk("t6_wex", 32'(wex), 32'd0);
            chk("t6_wey", 32'(wey), 32'd0);
        end

        // Randomized traffic with one mid-run reset
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                clrn = 1'b1;
                #1;
                chk("mid_rst_wex", 32'(wex), 32'd0);
                chk("mid_rst_wey", 32'(wey), 32'd0);
                model_clear();
                do_cycle();
                do_cycle();
                clrn = 1'b0;
            end
            for (int i = 0; i < 3; i++) begin
                if (!(get_v(i) && !m_rdy[i])) begin
                    if ($urandom_range(0, 99) < 70)
                        set_req(i, 1'b1, 5'($urandom_range(0, 9)), $urandom());
                    else
                        set_req(i, 1'b0, 5'd0, 32'd0);
                end
            end
            do_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
